// File: rtl/store_buffer.sv
// Circular store buffer: allocation at dispatch, fill from the LSU, commit marks from the ROB,
// in-order drain to data memory and youngest-match load forwarding.
module store_buffer #(
    parameter int SB_SIZE  = 5,
    parameter int SB_DEPTH = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Flush,
    input  logic               Alloc1_V,
    input  logic               Alloc2_V,
    output logic [SB_SIZE-1:0] SB_Addr1,
    output logic [SB_SIZE-1:0] SB_Addr2,
    output logic               SB_stall,
    input  logic               LSU_St_V,
    input  logic [SB_SIZE-1:0] LSU_St_Index,
    input  logic [15:0]        LSU_St_Addr,
    input  logic [15:0]        LSU_St_Data,
    input  logic               ROB_Retire1_SB_V,
    input  logic               ROB_Retire2_SB_V,
    input  logic [SB_SIZE-1:0] ROB_Retire1_SB_Addr,
    input  logic [SB_SIZE-1:0] ROB_Retire2_SB_Addr,
    output logic               Mem_Wr_En,
    output logic [15:0]        Mem_Wr_Addr,
    output logic [15:0]        Mem_Wr_Data,
    input  logic               Mem_Wr_Ready,
    input  logic               Ld_V,
    input  logic [15:0]        Ld_Addr,
    output logic               Fwd_Hit,
    output logic [15:0]        Fwd_Data
);
    localparam int CW = SB_SIZE + 1;

    logic [SB_DEPTH-1:0] valid;
    logic [SB_DEPTH-1:0] committed;
    logic [SB_DEPTH-1:0] filled;
    logic [SB_DEPTH-1:0] commit_eff;
    logic [15:0]         addr_q [SB_DEPTH];
    logic [15:0]         data_q [SB_DEPTH];
    logic [SB_SIZE-1:0]  ap;
    logic [SB_SIZE-1:0]  dp;
    logic [SB_SIZE-1:0]  fwd_idx;
    logic [CW-1:0]       free_cnt;
    logic [CW-1:0]       n_commit;
    logic [CW-1:0]       alloc_cnt;
    logic                drain;

    assign SB_stall  = free_cnt < CW'(2);
    assign SB_Addr1  = ap;
    assign SB_Addr2  = Alloc1_V ? ap + SB_SIZE'(1) : ap;
    assign alloc_cnt = SB_stall ? '0 : CW'(Alloc1_V) + CW'(Alloc2_V);

    assign Mem_Wr_En   = valid[dp] & committed[dp] & filled[dp];
    assign Mem_Wr_Addr = Mem_Wr_En ? addr_q[dp] : '0;
    assign Mem_Wr_Data = Mem_Wr_En ? data_q[dp] : '0;
    assign drain       = Mem_Wr_En & Mem_Wr_Ready;

    // Commit state as seen by a same-cycle flush: this cycle's retire marks already count.
    always_comb begin
        commit_eff = '0;
        n_commit   = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            commit_eff[i] = valid[i] &
                            (committed[i] |
                             (ROB_Retire1_SB_V && ROB_Retire1_SB_Addr == SB_SIZE'(i)) |
                             (ROB_Retire2_SB_V && ROB_Retire2_SB_Addr == SB_SIZE'(i)));
            n_commit = n_commit + CW'(commit_eff[i]);
        end
    end

    // Walk from oldest to youngest so the last match, the youngest store, wins.
    always_comb begin
        Fwd_Hit  = 1'b0;
        Fwd_Data = '0;
        fwd_idx  = '0;
        for (int k = SB_DEPTH - 1; k >= 0; k--) begin
            fwd_idx = ap - SB_SIZE'(1) - SB_SIZE'(k);
            if (Ld_V && valid[fwd_idx] && filled[fwd_idx] && addr_q[fwd_idx] == Ld_Addr) begin
                Fwd_Hit  = 1'b1;
                Fwd_Data = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid     <= '0;
            committed <= '0;
            filled    <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            ap       <= '0;
            dp       <= '0;
            free_cnt <= CW'(SB_DEPTH);
        end else begin
            if (!SB_stall && Alloc1_V) begin
                valid[SB_Addr1]     <= 1'b1;
                committed[SB_Addr1] <= 1'b0;
                filled[SB_Addr1]    <= 1'b0;
            end
            if (!SB_stall && Alloc2_V) begin
                valid[SB_Addr2]     <= 1'b1;
                committed[SB_Addr2] <= 1'b0;
                filled[SB_Addr2]    <= 1'b0;
            end
            if (LSU_St_V && valid[LSU_St_Index]) begin
                addr_q[LSU_St_Index] <= LSU_St_Addr;
                data_q[LSU_St_Index] <= LSU_St_Data;
                filled[LSU_St_Index] <= 1'b1;
            end
            if (ROB_Retire1_SB_V && valid[ROB_Retire1_SB_Addr]) begin
                committed[ROB_Retire1_SB_Addr] <= 1'b1;
            end
            if (ROB_Retire2_SB_V && valid[ROB_Retire2_SB_Addr]) begin
                committed[ROB_Retire2_SB_Addr] <= 1'b1;
            end
            // Later assignments override allocation and fill of anything the flush discards.
            if (Flush) begin
                for (int i = 0; i < SB_DEPTH; i++) begin
                    if (!commit_eff[i]) begin
                        valid[i]     <= 1'b0;
                        committed[i] <= 1'b0;
                        filled[i]    <= 1'b0;
                    end
                end
            end
            if (drain) begin
                valid[dp]     <= 1'b0;
                committed[dp] <= 1'b0;
                filled[dp]    <= 1'b0;
            end
            dp <= dp + SB_SIZE'(drain);
            if (Flush) begin
                ap       <= dp + n_commit[SB_SIZE-1:0];
                free_cnt <= CW'(SB_DEPTH) - n_commit + CW'(drain);
            end else begin
                ap       <= ap + alloc_cnt[SB_SIZE-1:0];
                free_cnt <= free_cnt - alloc_cnt + CW'(drain);
            end
        end
    end
endmodule
